pipeline_hazard_ctrl: RTL

Central stall/flush controller for the RV32Core 5-stage pipeline (IF/ID/EX/MEM/WB).
- Detects load-use hazards and redirects from JAL in ID and taken branch/JALR in EX.
- Sequences multi-cycle data-cache misses in MEM.
- Drives per-stage stall and flush; stall_wb feeds the WB write-enable gate, so a stalled WB never writes the regfile.
- Keeps miss/stall performance counters and a miss-timeout watchdog.

---
 rtl/pipe_ctrl_pkg.sv | 27 ++
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the RV32Core pipeline stall/flush controller.
package pipe_ctrl_pkg;

    // Controller FSM: normal flow, or holding the pipeline on a dcache miss.
    typedef enum logic [0:0] {
        RUN       = 1'b0,
        MISS_WAIT = 1'b1
    } ctrl_state_t;

    // Architectural zero register; never a real producer, so never a hazard.
    localparam logic [4:0] REG_X0 = 5'd0;

    // Per-stage hold/bubble controls, MSB first in pipeline order.
    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic stall_wb;
        logic flush_id;
        logic flush_ex;
        logic flush_wb;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t PIPE_CTRL_IDLE = 8'h00;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard detector: the load in EX writes a register that the
// instruction in ID actually reads. Purely combinational.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output logic       load_use
);

    logic rs1_hit_s;
    logic rs2_hit_s;

    // Only sources the ID instruction really consumes can create a hazard.
    assign rs1_hit_s = id_use_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit_s = id_use_rs2 & (id_rs2 == ex_rd);

    // A load targeting x0 produces nothing to wait for.
    assign load_use = ex_mem_read & (ex_rd != REG_X0) & (rs1_hit_s | rs2_hit_s);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage RV32Core pipeline.
// Stall/flush outputs are combinational from state and inputs; the miss
// FSM, watchdog and performance counters are registered.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MISS_TIMEOUT = 1024,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             jal_id,
    input  logic             br_taken_ex,
    input  logic             mem_req,
    input  logic             dcache_miss,
    input  logic             dcache_ready,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             stall_wb,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             flush_wb,
    output logic             miss_busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int                WAIT_W     = $clog2(MISS_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MISS_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    ctrl_state_t       state_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              timeout_err_r;
    logic [CNT_W-1:0]  miss_cnt_r;
    logic [CNT_W-1:0]  stall_cnt_r;

    logic              load_use_s;
    logic              miss_entry_s;
    logic              miss_stall_s;
    pipe_ctrl_t        ctrl_s;

    load_use_detect u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .load_use    (load_use_s)
    );

    // A new miss is only recognised in RUN; once waiting, the request is held.
    assign miss_entry_s = (state_r == RUN) & mem_req & dcache_miss;
    // Returned data releases the pipeline in the same cycle it arrives.
    assign miss_stall_s = (miss_entry_s | (state_r == MISS_WAIT)) & ~dcache_ready;

    // Priority mux: miss stall > taken branch/JALR > load-use > JAL.
    always_comb begin
        ctrl_s = PIPE_CTRL_IDLE;
        if (miss_stall_s) begin
            // Freeze IF..MEM; WB gets a bubble so nothing retires twice.
            ctrl_s.stall_if  = 1'b1;
            ctrl_s.stall_id  = 1'b1;
            ctrl_s.stall_ex  = 1'b1;
            ctrl_s.stall_mem = 1'b1;
            ctrl_s.flush_wb  = 1'b1;
        end else if (br_taken_ex) begin
            // Wrong-path instructions in ID and EX inputs are squashed.
            ctrl_s.flush_id  = 1'b1;
            ctrl_s.flush_ex  = 1'b1;
        end else if (load_use_s) begin
            // Hold IF/ID one cycle and insert a bubble behind the load;
            // a JAL in ID is simply re-presented next cycle.
            ctrl_s.stall_if  = 1'b1;
            ctrl_s.stall_id  = 1'b1;
            ctrl_s.flush_ex  = 1'b1;
        end else if (jal_id) begin
            ctrl_s.flush_id  = 1'b1;
        end else begin
            ctrl_s = PIPE_CTRL_IDLE;
        end
    end

    assign stall_if    = ctrl_s.stall_if;
    assign stall_id    = ctrl_s.stall_id;
    assign stall_ex    = ctrl_s.stall_ex;
    assign stall_mem   = ctrl_s.stall_mem;
    assign stall_wb    = ctrl_s.stall_wb;
    assign flush_id    = ctrl_s.flush_id;
    assign flush_ex    = ctrl_s.flush_ex;
    assign flush_wb    = ctrl_s.flush_wb;
    assign miss_busy   = (state_r == MISS_WAIT);
    assign timeout_err = timeout_err_r;
    assign miss_cnt    = miss_cnt_r;
    assign stall_cnt   = stall_cnt_r;

    // Miss FSM with watchdog; the FSM keeps waiting after a timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= RUN;
            wait_cnt_r    <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (miss_entry_s && !dcache_ready) begin
                        state_r    <= MISS_WAIT;
                        wait_cnt_r <= '0;
                    end else begin
                        state_r    <= RUN;
                    end
                end
                MISS_WAIT: begin
                    if (dcache_ready) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= MISS_WAIT;
                    end
                    // Saturate so a very long wait cannot wrap the counter.
                    if (wait_cnt_r != WAIT_LIMIT) begin
                        wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r;
                    end
                    // Flag goes up on the edge where the count reaches the limit.
                    if (wait_cnt_r >= (WAIT_LIMIT - WAIT_ONE)) begin
                        timeout_err_r <= 1'b1;
                    end else begin
                        timeout_err_r <= timeout_err_r;
                    end
                end
                default: begin
                    state_r    <= RUN;
                    wait_cnt_r <= '0;
                end
            endcase
        end
    end

    // Performance counters, wrapping modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_cnt_r  <= '0;
            stall_cnt_r <= '0;
        end else begin
            if (miss_entry_s) begin
                miss_cnt_r <= miss_cnt_r + CNT_ONE;
            end else begin
                miss_cnt_r <= miss_cnt_r;
            end
            if (ctrl_s.stall_if) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

endmodule
